// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// The PARITY state is only entered when PISO_PARITY_EN is defined.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Bit-counter width for a WIDTH-bit frame.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register in front of the shift register.
// Owns hold_full and generates load_ready.
module piso_hold_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             store_i,
    input  logic             take_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             ready_o
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (store_i) data_q <= data_i;
            // store and take never coincide: ready is low while full
            if (take_i)       full_q <= 1'b0;
            else if (store_i) full_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign full_o  = full_q;
    assign ready_o = rst & ~full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word hold register for gapless frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | no frame in flight, dout_valid low
//   ST_SHIFT  | emitting data bits, cnt_q = index of bit on dout
//   ST_PARITY | emitting the parity bit (PISO_PARITY_EN only)
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

    localparam int            CW         = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             dout_q;
    logic             valid_q;
    logic             last_q;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    logic             accept;
    logic             frame_end;
    logic             take;
    logic             store;
    logic             do_load;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic [WIDTH-1:0] load_word;
    logic             load_bit;
    logic [WIDTH-1:0] load_rest;
    logic             next_bit;
    logic [WIDTH-1:0] shift_rest;

    piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .data_i  (load_data),
        .store_i (store),
        .take_i  (take),
        .data_o  (hold_data),
        .full_o  (hold_full),
        .ready_o (load_ready)
    );

    always_comb begin
        accept = load_valid & load_ready;
`ifdef PISO_PARITY_EN
        frame_end = (state_q == ST_PARITY);
`else
        frame_end = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
`endif
        take      = frame_end & hold_full;
        // A held word always wins at frame end; ready is low then anyway.
        do_load   = take | (accept & ((state_q == ST_IDLE) | frame_end));
        store     = accept & (state_q != ST_IDLE) & ~frame_end;
        load_word = hold_full ? hold_data : load_data;
        if (MSB_FIRST) begin
            load_bit   = load_word[WIDTH-1];
            load_rest  = {load_word[WIDTH-2:0], 1'b0};
            next_bit   = shreg_q[WIDTH-1];
            shift_rest = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            load_bit   = load_word[0];
            load_rest  = {1'b0, load_word[WIDTH-1:1]};
            next_bit   = shreg_q[0];
            shift_rest = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (do_load) begin
            state_q <= ST_SHIFT;
            shreg_q <= load_rest;
            cnt_q   <= '0;
            dout_q  <= load_bit;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= ^load_word;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q != CNT_LAST) begin
                        shreg_q <= shift_rest;
                        cnt_q   <= cnt_q + CW'(1);
                        dout_q  <= next_bit;
`ifdef PISO_PARITY_EN
                        last_q  <= 1'b0;
`else
                        last_q  <= (cnt_q == CNT_PENULT);
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state_q <= ST_PARITY;
                        dout_q  <= par_q;
                        last_q  <= 1'b1;
`else
                        state_q <= ST_IDLE;
                        dout_q  <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    dout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign busy       = (state_q != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first instance.
// Honours PISO_PARITY_EN when it is defined for the build.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] m_data = '0, l_data = '0;
    logic m_valid = 1'b0, l_valid = 1'b0;
    logic m_ready, m_dout, m_dv, m_last, m_busy;
    logic l_ready, l_dout, l_dv, l_last, l_busy;

    int errors = 0;
    int checks = 0;
    logic [1:0] m_q[$];
    logic [1:0] l_q[$];
    int m_run = 0;
    int m_last_run = 0;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .load_data(m_data), .load_valid(m_valid),
        .load_ready(m_ready), .dout(m_dout), .dout_valid(m_dv),
        .dout_last(m_last), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_data(l_data), .load_valid(l_valid),
        .load_ready(l_ready), .dout(l_dout), .dout_valid(l_dv),
        .dout_last(l_last), .busy(l_busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_frame(input bit sel, input logic [W-1:0] w);
        logic [1:0] e;
        for (int i = 0; i < W; i++) begin
            e[1] = sel ? w[i] : w[W-1-i];
            e[0] = (i == W - 1) && (PAR == 0);
            if (sel) l_q.push_back(e);
            else     m_q.push_back(e);
        end
        if (PAR != 0) begin
            e = {^w, 1'b1};
            if (sel) l_q.push_back(e);
            else     m_q.push_back(e);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input bit sel, input logic [W-1:0] w, output int stalls);
        bit rdy;
        bit done;
        stalls = 0;
        done   = 1'b0;
        if (sel) begin l_data = w; l_valid = 1'b1; end
        else     begin m_data = w; m_valid = 1'b1; end
        for (int n = 0; n < 100; n++) begin
            rdy = sel ? l_ready : m_ready;
            @(posedge clk);
            if (rdy) begin
                push_frame(sel, w);
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        @(negedge clk);
        if (sel) l_valid = 1'b0;
        else     m_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input bit sel);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (sel ? (!l_dv && !l_busy) : (!m_dv && !m_busy)) begin
                done = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (m_dv) begin
            m_run++;
            if (m_q.size() == 0) check("m_extra_bit", 32'd1, 32'd0);
            else begin
                e = m_q.pop_front();
                check("m_dout", 32'(m_dout), 32'(e[1]));
                check("m_last", 32'(m_last), 32'(e[0]));
            end
        end else begin
            check("m_idle_out", 32'({m_dout, m_last}), 32'd0);
            if (m_run != 0) begin
                m_last_run = m_run;
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (l_dv) begin
            if (l_q.size() == 0) check("l_extra_bit", 32'd1, 32'd0);
            else begin
                e = l_q.pop_front();
                check("l_dout", 32'(l_dout), 32'(e[1]));
                check("l_last", 32'(l_last), 32'(e[0]));
            end
        end else begin
            check("l_idle_out", 32'({l_dout, l_last}), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(m_ready), 32'd0);
        check("rst_valid", 32'(m_dv), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(m_ready), 32'd1);

        // single word
        send(1'b0, 8'hA5, st);
        check("first_bit_latency", 32'(m_dv), 32'd1);
        wait_idle(1'b0);
        check("single_len", 32'(m_last_run), 32'(FL));
        check("single_busy", 32'(m_busy), 32'd0);
        check("single_sb_empty", 32'(m_q.size()), 32'd0);

        // back-to-back
        send(1'b0, 8'hA5, st);
        send(1'b0, 8'h3C, st);
        check("b2b_stall", 32'(st), 32'd0);
        wait_idle(1'b0);
        check("b2b_len", 32'(m_last_run), 32'(2 * FL));
        check("b2b_sb_empty", 32'(m_q.size()), 32'd0);

        // backpressure with three words
        send(1'b0, 8'h96, st);
        send(1'b0, 8'h5A, st);
        check("bp_second_stall", 32'(st), 32'd0);
        send(1'b0, 8'hC3, st);
        check("bp_third_stall", 32'(st), 32'(FL - 1));
        wait_idle(1'b0);
        check("bp_len", 32'(m_last_run), 32'(3 * FL));
        check("bp_sb_empty", 32'(m_q.size()), 32'd0);

        // odd-parity word
        send(1'b0, 8'h07, st);
        wait_idle(1'b0);
        check("w07_len", 32'(m_last_run), 32'(FL));

        // LSB-first instance
        send(1'b1, 8'h01, st);
        check("lsb_latency", 32'(l_dv), 32'd1);
        wait_idle(1'b1);
        check("lsb_sb_empty", 32'(l_q.size()), 32'd0);

        // reset mid-frame with a held word
        send(1'b0, 8'hFF, st);
        send(1'b0, 8'h0F, st);
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(m_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", 32'(m_dv), 32'd0);
        check("midrst_dout", 32'(m_dout), 32'd0);
        check("midrst_last", 32'(m_last), 32'd0);
        check("midrst_busy", 32'(m_busy), 32'd0);
        check("midrst_ready", 32'(m_ready), 32'd0);
        m_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_ready", 32'(m_ready), 32'd1);
        check("rel_busy", 32'(m_busy), 32'd0);
        repeat (20) @(negedge clk);
        check("no_residual_busy", 32'(m_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the serial shift-register chain. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on dout/dout_valid.
- A one-word holding register allows back-to-back frames with no idle bit between them.
- dout_last marks the final bit of each frame for downstream framing.

Parameters:
- WIDTH, 8, data word width in bits; must be at least 2.
- MSB_FIRST, 1, bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_data  input  WIDTH  parallel word to serialize.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data bit, registered.
- dout_valid  output  1  dout carries a frame bit, registered.
- dout_last  output  1  current bit is the final bit of the frame, registered.
- busy  output  1  a frame is shifting or a word is held.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - shift register, hold register, hold_full and bit counter are all cleared.
  - dout=0, dout_valid=0, dout_last=0, busy=0.
  - load_ready=0 while rst=0.
- load_ready = rst & ~hold_full (combinational).
- A word is accepted on a rising edge where load_valid & load_ready.
- States: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- IDLE:
  - An accepted word loads straight into the shift register and the counter is set to 0.
  - Next state is SHIFT.
  - The first bit appears on dout with dout_valid=1 in the cycle after acceptance (1-cycle latency).
- SHIFT:
  - Each edge shifts by one bit and the counter increments.
  - Words accepted during SHIFT go into the hold register; hold_full is set.
  - At the edge ending the last bit (counter = WIDTH-1):
    - If hold_full: hold moves into the shift register, hold_full clears, counter goes to 0, state stays SHIFT. No gap between frames.
    - Else, if a word is accepted on that same edge (hold empty, so ready=1): the word goes directly into the shift register, state stays SHIFT. No gap.
    - Else: next state is IDLE and dout_valid=0.
- Holding register full while shifting: load_ready=0 until the hold word transfers at frame end. The transfer edge cannot accept a new word because load_ready was 0 during that cycle. load_ready returns to 1 the cycle after.
- dout_last=1 exactly on the final bit of each frame.
- dout is forced to 0 whenever dout_valid=0.
- busy = (state != IDLE) | hold_full.
- Reset mid-frame: the frame and any held word are discarded, and outputs drop immediately (asynchronously).
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one PARITY-state cycle emits the even-parity bit (XOR of the frame word) with dout_valid=1 and dout_last=1. dout_last is not asserted on the final data bit.
  - The frame is WIDTH+1 cycles long.
  - The hold transfer and same-edge load rules apply at the end of the PARITY cycle instead of the last data bit.
  - The parity bit is computed at load time and stored alongside the word.
- Undefined: there is no PARITY state and frames are WIDTH cycles long.

Decomposition:
- Shared package piso_pkg:
  - state typedef (IDLE, SHIFT, PARITY).
  - CNT_W helper function ($clog2 wrapper).
- One natural sub-module, piso_hold_reg: the one-entry holding register with hold_full, load_ready generation and a take strobe. The top-level keeps the FSM, counter and shift register.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1: load 8'hA5. dout_valid high for cycles 1-8 after acceptance, dout=1,0,1,0,0,1,0,1, dout_last only on cycle 8. Then IDLE, busy=0.
- Back-to-back: load 8'hA5, then 8'h3C on the next cycle. 16 consecutive dout_valid cycles with no gap; second frame bits 0,0,1,1,1,1,0,0; dout_last on cycles 8 and 16.
- Backpressure: keep load_valid high with three words. After the second word is held, load_ready=0 until the first frame's final edge, rises one cycle later, and the third word follows with no data loss.
- MSB_FIRST=0: load 8'h01. dout=1 then seven 0s, dout_last on the 8th bit.
- Reset mid-frame: assert rst=0 during bit 4 of 8'hFF with 8'h0F held. Outputs go to 0 immediately. After release, load_ready=1 and no residual bits are emitted.
- With PISO_PARITY_EN:
  - 8'hA5 gives 9 valid cycles, 9th bit = 0 with dout_last.
  - 8'h07 gives 9th bit = 1.
